text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter CLEAR_CHAR, default 8'h20, character code written by clear and scroll fill.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 s_data  in  8  character/control byte; s_attr  in  8  cell colour (fg [7:4], bg [3:0]); both sampled on transfer.
REQ-005 s_valid  in  1 / s_ready  out  1  byte-stream handshake.
REQ-006 vram_addr  out  11  [10]=0 text plane, [10]=1 colour plane, [9:0] cell index row*40+col.
REQ-007 vram_wrdata  out  8, vram_wren  out  1, vram_rddata  in  8  (registered read, valid one cycle after address).
REQ-008 cursor_col  out  6, cursor_row  out  5, busy  out  1 (high whenever s_ready low).

Function
REQ-009 Transfer occurs when s_valid && s_ready; s_ready SHALL be high only in IDLE.
REQ-010 States: IDLE, PUT_TXT, PUT_COL, CLEAR, SCR_RD_T, SCR_WR_T, SCR_RD_C, SCR_WR_C.
REQ-011 Printable byte (not 0x08/0x0A/0x0C/0x0D) accepted at T: T+1 write {0,idx}=byte; T+2 write {1,idx}=attr; s_ready high at T+3 unless scroll pending.
REQ-012 After PUT_COL col increments; col 40 -> col 0, row+1.
REQ-013 0x0D: col=0; 0x0A: col=0, row+1; 0x08: col-1 if col>0 else no change; all applied in transfer cycle, s_ready stays high unless row overflows.
REQ-014 0x0C: enter CLEAR over cells 0..999, cursor to (0,0) on completion.
REQ-015 CLEAR: per cell two cycles, text write CLEAR_CHAR then colour write latched attr; 2000 cycles for full screen.
REQ-016 Row reaching 25 SHALL trigger scroll: for i=0..959 four cycles: read {0,i+40}, write {0,i}=vram_rddata, read {1,i+40}, write {1,i}=vram_rddata.
REQ-017 Scroll then clears cells 960..999 (80 cycles) with CLEAR_CHAR and latched attr; total 3920 cycles; cursor ends at (24,0).
REQ-018 Cell index computed as row*32+row*8+col, 10 bits, never exceeding 999 on any write.
REQ-019 vram_wren high exactly one cycle per write; vram_addr/wrdata held stable that cycle.
REQ-020 s_valid while busy SHALL be ignored; no byte lost (upstream holds).

Reset
REQ-021 During reset: vram_wren=0, vram_addr=0, vram_wrdata=0, s_ready=0, busy=1, cursor (0,0), latched attr 8'h00.
REQ-022 On reset release SHALL enter CLEAR (2000 cycles), then IDLE with s_ready=1.
REQ-023 Reset mid-scroll or mid-clear SHALL abort immediately; no further writes until release.

Configuration
REQ-024 Macro TEXT_CONSOLE_SCROLL_EN defined: row overflow scrolls per REQ-016/017.
REQ-025 Undefined: row overflow sets cursor to (0,0), no scroll states synthesised, s_ready unaffected.

Structure
REQ-026 Package text_console_pkg SHALL hold COLS=40, ROWS=25, CELLS=1000, control codes, state enum.
REQ-027 No sub-module; address shift-add inline.

Verification
REQ-028 Release reset -> 2000 writes alternating {0,i}=0x20,{1,i}=0x00 for i=0..999, then s_ready=1.
REQ-029 Send 'A' attr 8'h71 at (0,0) -> write 0x000=0x41, 0x400=0x71; cursor (0,1); s_ready high 3 cycles after transfer.
REQ-030 Cursor (3,39), send 'Z' -> writes at index 159; cursor (4,0).
REQ-031 Preload row1 cells, cursor (24,5), send 0x0A -> 3920 busy cycles, row0 equals old row1, cells 960..999 = 0x20, cursor (24,0).
REQ-032 Send 0x08 at col 0 -> cursor unchanged; 0x0C -> 2000 writes, cursor (0,0).
REQ-033 Assert reset at scroll cycle 100 -> wren 0 immediately; after release full clear runs.

Source files
------------

// File: rtl/text_console_pkg.sv
// text_console_pkg - screen geometry, control codes and FSM states shared by
// the text console and its testbench.
package text_console_pkg;

  localparam int COLS  = 40;
  localparam int ROWS  = 25;
  localparam int CELLS = 1000;

  localparam logic [4:0] LAST_ROW    = 5'(ROWS - 1);
  localparam logic [5:0] LAST_COL    = 6'(COLS - 1);
  localparam logic [9:0] LAST_CELL   = 10'(CELLS - 1);
  localparam logic [9:0] ROW_STRIDE  = 10'(COLS);
  localparam logic [9:0] LAST_SCROLL = 10'(CELLS - COLS - 1);
  localparam logic [9:0] FIRST_FILL  = 10'(CELLS - COLS);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    PUT_TXT,
    PUT_COL,
    CLEAR,
    SCR_RD_T,
    SCR_WR_T,
    SCR_RD_C,
    SCR_WR_C
  } state_t;

endpackage

// File: rtl/text_console.sv
// text_console - turns a byte stream into writes to a 40x25 text/colour VRAM,
// handling CR, LF, BS and form-feed (clear screen).
// Optional feature: define TEXT_CONSOLE_SCROLL_EN to scroll the screen up one
// row when the cursor runs off the bottom; without it the cursor wraps to (0,0).
module text_console
  import text_console_pkg::*;
#(
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic [7:0]  s_attr,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [10:0] vram_addr,
  output logic [7:0]  vram_wrdata,
  output logic        vram_wren,
  input  logic [7:0]  vram_rddata,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  state_t      state, state_n;
  logic [4:0]  row_q, row_n;
  logic [5:0]  col_q, col_n;
  logic [7:0]  char_q, char_n;
  logic [7:0]  attr_q, attr_n;
  logic [9:0]  cnt_q, cnt_n;
  logic        phase_q, phase_n;
  logic        home_q, home_n;
  logic        wrap;

  logic        ready_c;
  logic        wren_c;
  logic [10:0] addr_c;
  logic [7:0]  data_c;
  logic [9:0]  cell_idx;

  // row*40 as row*32 + row*8; row <= 24 and col <= 39 keep this below 1000
  assign cell_idx = {row_q, 5'b0} + {2'b0, row_q, 3'b0} + {4'b0, col_q};

`ifdef TEXT_CONSOLE_SCROLL_EN
  logic [9:0] src_idx;
  assign src_idx = cnt_q + ROW_STRIDE;
`else
  logic unused_rddata;
  assign unused_rddata = ^vram_rddata;
`endif

  // State and datapath registers; reset lands in CLEAR so the screen is wiped
  // as soon as reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= CLEAR;
      row_q   <= '0;
      col_q   <= '0;
      char_q  <= '0;
      attr_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      home_q  <= 1'b1;
    end else begin
      state   <= state_n;
      row_q   <= row_n;
      col_q   <= col_n;
      char_q  <= char_n;
      attr_q  <= attr_n;
      cnt_q   <= cnt_n;
      phase_q <= phase_n;
      home_q  <= home_n;
    end
  end

  // Next-state, cursor movement and VRAM port drive for every state.
  always_comb begin
    state_n = state;
    row_n   = row_q;
    col_n   = col_q;
    char_n  = char_q;
    attr_n  = attr_q;
    cnt_n   = cnt_q;
    phase_n = phase_q;
    home_n  = home_q;
    wrap    = 1'b0;
    ready_c = 1'b0;
    wren_c  = 1'b0;
    addr_c  = '0;
    data_c  = '0;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (s_valid) begin
          char_n = s_data;
          attr_n = s_attr;
          case (s_data)
            CH_CR: col_n = '0;
            CH_LF: begin
              col_n = '0;
              if (row_q == LAST_ROW) wrap = 1'b1;
              else                   row_n = row_q + 5'd1;
            end
            CH_BS: begin
              if (col_q != '0) col_n = col_q - 6'd1;
            end
            CH_FF: begin
              state_n = CLEAR;
              cnt_n   = '0;
              phase_n = 1'b0;
              home_n  = 1'b1;
            end
            default: state_n = PUT_TXT;
          endcase
        end
      end

      PUT_TXT: begin
        wren_c  = 1'b1;
        addr_c  = {1'b0, cell_idx};
        data_c  = char_q;
        state_n = PUT_COL;
      end

      PUT_COL: begin
        wren_c  = 1'b1;
        addr_c  = {1'b1, cell_idx};
        data_c  = attr_q;
        state_n = IDLE;
        if (col_q == LAST_COL) begin
          col_n = '0;
          if (row_q == LAST_ROW) wrap = 1'b1;
          else                   row_n = row_q + 5'd1;
        end else begin
          col_n = col_q + 6'd1;
        end
      end

      CLEAR: begin
        wren_c  = 1'b1;
        addr_c  = {phase_q, cnt_q};
        data_c  = phase_q ? attr_q : CLEAR_CHAR;
        phase_n = ~phase_q;
        if (phase_q) begin
          if (cnt_q == LAST_CELL) begin
            state_n = IDLE;
            if (home_q) begin
              row_n = '0;
              col_n = '0;
            end
          end else begin
            cnt_n = cnt_q + 10'd1;
          end
        end
      end

`ifdef TEXT_CONSOLE_SCROLL_EN
      SCR_RD_T: begin
        addr_c  = {1'b0, src_idx};
        state_n = SCR_WR_T;
      end

      SCR_WR_T: begin
        wren_c  = 1'b1;
        addr_c  = {1'b0, cnt_q};
        data_c  = vram_rddata;
        state_n = SCR_RD_C;
      end

      SCR_RD_C: begin
        addr_c  = {1'b1, src_idx};
        state_n = SCR_WR_C;
      end

      SCR_WR_C: begin
        wren_c = 1'b1;
        addr_c = {1'b1, cnt_q};
        data_c = vram_rddata;
        if (cnt_q == LAST_SCROLL) begin
          state_n = CLEAR;
          cnt_n   = FIRST_FILL;
          phase_n = 1'b0;
          home_n  = 1'b0;
        end else begin
          cnt_n   = cnt_q + 10'd1;
          state_n = SCR_RD_T;
        end
      end
`endif

      default: state_n = IDLE;
    endcase

    if (wrap) begin
`ifdef TEXT_CONSOLE_SCROLL_EN
      state_n = SCR_RD_T;
      cnt_n   = '0;
      row_n   = LAST_ROW;
      col_n   = '0;
`else
      row_n   = '0;
      col_n   = '0;
`endif
    end
  end

  // Reset forces the VRAM port quiet and the stream closed straight away,
  // even in the middle of a clear or scroll.
  assign s_ready     = ready_c & ~reset;
  assign busy        = ~s_ready;
  assign vram_wren   = wren_c & ~reset;
  assign vram_addr   = reset ? 11'd0 : addr_c;
  assign vram_wrdata = reset ? 8'd0 : data_c;
  assign cursor_col  = col_q;
  assign cursor_row  = row_q;

endmodule

// File: tb/tb_text_console.sv
// tb_text_console - scoreboard bench for text_console: every byte sent pushes
// the VRAM writes it should cause, a monitor pops them as the DUT writes.
// Build with TEXT_CONSOLE_SCROLL_EN defined to exercise the scroll path.
`timescale 1ns/1ps
module tb_text_console;
  import text_console_pkg::*;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  s_data = '0;
  logic [7:0]  s_attr = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [10:0] vram_addr;
  logic [7:0]  vram_wrdata;
  logic        vram_wren;
  logic [7:0]  vram_rddata;
  logic [5:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  logic [7:0]  vram    [0:2047];
  logic [7:0]  exp_mem [0:2047];
  wr_t         exp_q[$];
  wr_t         mon_e;
  int          errors = 0;
  int          checks = 0;
  int          exp_row = 0;
  int          exp_col = 0;
  int          cyc;

  always #5 clk = ~clk;

  text_console #(.CLEAR_CHAR(8'h20)) dut (
    .clk         (clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_attr      (s_attr),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .vram_addr   (vram_addr),
    .vram_wrdata (vram_wrdata),
    .vram_wren   (vram_wren),
    .vram_rddata (vram_rddata),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  // VRAM with a registered read port
  always @(posedge clk) begin
    vram_rddata <= vram[vram_addr];
    if (vram_wren) vram[vram_addr] <= vram_wrdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // monitor: every DUT write must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && vram_wren) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: actual addr=0x%0h data=0x%0h required none",
                 vram_addr, vram_wrdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", {21'd0, vram_addr}, {21'd0, mon_e.addr});
        checkOutput("wr_data", {24'd0, vram_wrdata}, {24'd0, mon_e.data});
      end
    end
  end

  task automatic pushWrite(input int addr, input logic [7:0] data);
    wr_t w;
    w.addr = 11'(addr);
    w.data = data;
    exp_q.push_back(w);
    exp_mem[addr] = data;
  endtask

  task automatic pushClear(input logic [7:0] attr, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      pushWrite(i, 8'h20);
      pushWrite(1024 + i, attr);
    end
  endtask

  task automatic overflow(input logic [7:0] attr);
`ifdef TEXT_CONSOLE_SCROLL_EN
    for (int i = 0; i < 960; i++) begin
      pushWrite(i, exp_mem[i + 40]);
      pushWrite(1024 + i, exp_mem[1024 + i + 40]);
    end
    pushClear(attr, 960, 999);
    exp_row = 24;
    exp_col = 0;
`else
    exp_row = 0;
    exp_col = 0;
`endif
  endtask

  task automatic sendByte(input logic [7:0] d, input logic [7:0] a);
    int n = 0;
    s_data  = d;
    s_attr  = a;
    s_valid = 1'b1;
    while (!s_ready && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) checkOutput("send_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // model the byte's effect on cursor and VRAM, then hand it to the DUT
  task automatic applyStimulus(input logic [7:0] d, input logic [7:0] a);
    case (d)
      8'h0D: exp_col = 0;
      8'h0A: begin
        exp_col = 0;
        if (exp_row == 24) overflow(a);
        else exp_row++;
      end
      8'h08: if (exp_col > 0) exp_col--;
      8'h0C: begin
        pushClear(a, 0, 999);
        exp_row = 0;
        exp_col = 0;
      end
      default: begin
        pushWrite(exp_row * 40 + exp_col, d);
        pushWrite(1024 + exp_row * 40 + exp_col, a);
        exp_col++;
        if (exp_col == 40) begin
          exp_col = 0;
          if (exp_row == 24) overflow(a);
          else exp_row++;
        end
      end
    endcase
    sendByte(d, a);
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!s_ready && cycles < 10000) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic checkCursor(input string name);
    checkOutput({name, "_row"}, {27'd0, cursor_row}, 32'(exp_row));
    checkOutput({name, "_col"}, {26'd0, cursor_col}, 32'(exp_col));
  endtask

  task automatic sendPrint(input logic [7:0] d, input logic [7:0] a);
    applyStimulus(d, a);
    waitIdle(cyc);
    checkOutput("print_busy", 32'(cyc), 32'd2);
  endtask

  task automatic sendCtrl(input logic [7:0] d, input logic [7:0] a);
    applyStimulus(d, a);
    @(negedge clk);
    checkOutput("ctrl_ready", {31'd0, s_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wren", {31'd0, vram_wren}, 32'd0);
    checkOutput("rst_addr", {21'd0, vram_addr}, 32'd0);
    checkOutput("rst_wrdata", {24'd0, vram_wrdata}, 32'd0);
    checkOutput("rst_ready", {31'd0, s_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkCursor("rst_cursor");

    // release: full clear with the reset attribute 0x00
    pushClear(8'h00, 0, 999);
    reset = 1'b0;
    waitIdle(cyc);
    checkOutput("init_clear_cycles", 32'(cyc), 32'd2000);
    checkOutput("init_ready", {31'd0, s_ready}, 32'd1);

    // 'A' at (0,0): two writes then ready on the third cycle
    applyStimulus(8'h41, 8'h71);
    @(negedge clk);
    checkOutput("A_busy_c1", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    checkOutput("A_busy_c2", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    checkOutput("A_ready_c3", {31'd0, s_ready}, 32'd1);
    checkCursor("A_cursor");

    // backspace, then backspace at column 0 leaves the cursor alone
    sendCtrl(8'h08, 8'h07);
    checkCursor("bs1_cursor");
    sendCtrl(8'h08, 8'h07);
    checkCursor("bs0_cursor");

    // fill row 1 with a known pattern for the scroll test
    sendCtrl(8'h0A, 8'h07);
    checkCursor("lf_cursor");
    for (int j = 0; j < 40; j++) sendPrint(8'h30 + 8'(j), 8'h80 + 8'(j));
    checkCursor("row1_wrap_cursor");

    // walk to (3,39), then 'Z' lands at cell 159 and wraps the line
    sendCtrl(8'h0A, 8'h07);
    for (int j = 0; j < 39; j++) sendPrint(8'h41 + 8'(j % 26), 8'h07);
    checkCursor("r3c39_cursor");
    sendPrint(8'h5A, 8'h2C);
    checkCursor("Z_cursor");

    // move to (24,5)
    for (int j = 0; j < 20; j++) sendCtrl(8'h0A, 8'h07);
    sendCtrl(8'h0D, 8'h07);
    checkCursor("row24_cursor");
    for (int j = 0; j < 5; j++) sendPrint(8'h61 + 8'(j), 8'h0F);
    checkCursor("r24c5_cursor");

`ifdef TEXT_CONSOLE_SCROLL_EN
    applyStimulus(8'h0A, 8'h5A);
    waitIdle(cyc);
    checkOutput("scroll_cycles", 32'(cyc), 32'd3920);
    checkCursor("scroll_cursor");
    bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (vram[j] !== 8'h30 + 8'(j)) bad++;
      if (vram[1024 + j] !== 8'h80 + 8'(j)) bad++;
    end
    checkOutput("scroll_row0_bad", 32'(bad), 32'd0);
    bad = 0;
    for (int j = 960; j < 1000; j++) begin
      if (vram[j] !== 8'h20) bad++;
      if (vram[1024 + j] !== 8'h5A) bad++;
    end
    checkOutput("scroll_fill_bad", 32'(bad), 32'd0);
`else
    sendCtrl(8'h0A, 8'h5A);
    checkCursor("wrap_home_cursor");
`endif

    // form feed clears with the new attribute and homes the cursor
    sendPrint(8'h51, 8'h07);
    applyStimulus(8'h0C, 8'h1E);
    waitIdle(cyc);
    checkOutput("ff_cycles", 32'(cyc), 32'd2000);
    checkCursor("ff_cursor");

    // reset in the middle of a clear stops writes at once
    sendPrint(8'h51, 8'h07);
    applyStimulus(8'h0C, 8'h33);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_wren", {31'd0, vram_wren}, 32'd0);
    checkOutput("midrst_ready", {31'd0, s_ready}, 32'd0);
    exp_q.delete();
    exp_row = 0;
    exp_col = 0;
    checkCursor("midrst_cursor");
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_hold_wren", {31'd0, vram_wren}, 32'd0);
    end
    @(posedge clk);
    #1;
    pushClear(8'h00, 0, 999);
    reset = 1'b0;
    waitIdle(cyc);
    checkOutput("rerst_clear_cycles", 32'(cyc), 32'd2000);
    checkOutput("rerst_ready", {31'd0, s_ready}, 32'd1);
    checkCursor("rerst_cursor");

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
